tiny45_mem_arbiter: RTL and testbench
=====================================

// Module: tiny45_mem_arbiter
// PURPOSE
//  Shares the single nibble-serial memory port between the instruction fetcher and the
//  tiny45 core's load/store path. Latches each request's address/length, issues one
//  start pulse to the memory controller, and counts nibble handshakes to completion.
//  Routes read/write nibbles to the owner. Supports cancelling a fetch on branch.
// PARAMETERS
//  FETCH_NIBBLES  8  nibbles per instruction fetch, legal range 1..15
// PORTS
//  clk             in   1   clock
//  rstn            in   1   synchronous reset, active low
//  instr_req       in   1   fetch request; level, held until instr_done or cancel
//  instr_addr      in   28  fetch address, sampled on grant
//  instr_cancel    in   1   abort the fetch (branch taken)
//  instr_rdata     out  4   fetched nibble (= mem_rdata)
//  instr_rvalid    out  1   instr_rdata valid this cycle
//  instr_done      out  1   last fetch nibble accepted this cycle
//  data_req        in   1   load/store request; level, held until data_done
//  data_addr       in   28  load/store address, sampled on grant
//  data_write      in   1   1 = store, 0 = load; sampled on grant
//  data_size       in   2   00 byte (2 nibbles), 01 half (4), 10/11 word (8)
//  data_wdata      in   4   store nibble, LS nibble first
//  data_wnext      out  1   data_wdata consumed this cycle; present next nibble
//  data_rdata      out  4   load nibble (= mem_rdata)
//  data_rvalid     out  1   data_rdata valid this cycle
//  data_done       out  1   last data nibble transferred this cycle
//  mem_start       out  1   one-cycle pulse: transaction begins
//  mem_addr        out  28  registered transaction address, stable until IDLE
//  mem_write       out  1   registered direction
//  mem_nibbles     out  4   registered transaction length in nibbles
//  mem_wdata       out  4   write nibble (= data_wdata)
//  mem_wready      in   1   memory accepts mem_wdata this cycle
//  mem_rdata       in   4   read nibble
//  mem_rvalid      in   1   mem_rdata valid this cycle
//  mem_stop        out  1   abort current transaction (fetch cancel)
// BEHAVIOUR
//  - States: IDLE, FETCH, DREAD, DWRITE. rstn=0: state IDLE, counter 0, all registered
//    outputs 0; every output is 0 in IDLE except mem_addr/write/nibbles (hold last value,
//    0 after reset). Reset mid-transaction drops it silently; memory shares rstn.
//  - Arbitration in IDLE only. Data wins over fetch, except when the previous transaction
//    was data and instr_req is high: then fetch wins (last_was_data flag, reset 0).
//  - Grant latency: request high in IDLE cycle N -> state/mem_start/mem_addr/mem_write/
//    mem_nibbles valid cycle N+1. mem_start high only in the first active cycle.
//  - Counter (4 bit) loaded with length on grant; decrements on mem_rvalid (FETCH/DREAD)
//    or mem_wready (DWRITE). Ack with counter==1: done asserted combinationally that
//    cycle, state -> IDLE next cycle. Next request may start 2 cycles after done.
//  - Handshakes ignored in IDLE and in a non-matching state (mem_rvalid in DWRITE etc.).
//  - instr_rvalid = mem_rvalid & FETCH & !instr_cancel; data_rvalid = mem_rvalid & DREAD;
//    data_wnext = mem_wready & DWRITE. Ack allowed in the mem_start cycle.
//  - Cancel: instr_cancel in FETCH -> mem_stop=1 same cycle (combinational), no
//    instr_rvalid/instr_done, state -> IDLE next cycle. Cancel on the last-nibble cycle:
//    cancel wins. Cancel in IDLE blocks a fetch grant that cycle; no mem_stop.
//    Cancel in DREAD/DWRITE: no effect.
//  - Requester dropping req mid-transaction is illegal (fetch must use cancel).
// TESTING
//  - Fetch 0x0000100, mem_rvalid every cycle, nibbles 3,0,0,0,0,0,0,0 -> start at N+1,
//    mem_nibbles=8, 8 instr_rvalid, instr_done on 8th, IDLE next.
//  - instr_req and data_req (load, size 00, 0x1000004) same IDLE cycle -> data first,
//    mem_nibbles=2; then fetch granted before a re-raised data_req.
//  - Store word 0x12345678, mem_wready every other cycle -> mem_write=1, 8 data_wnext,
//    nibbles 8,7,6,5,4,3,2,1 on mem_wdata, data_done on 8th mem_wready.
//  - Cancel after 3 fetch nibbles -> mem_stop 1 cycle, no instr_done, IDLE next; pending
//    data_req granted following cycle.
//  - rstn low mid DWRITE after 2 nibbles -> IDLE, all outputs 0 next cycle; fresh fetch OK.
//  - instr_cancel coincident with 8th nibble -> mem_stop=1, instr_done=0, instr_rvalid=0.

Source files
------------

// File: rtl/tiny45_mem_arbiter.sv
// tiny45_mem_arbiter: shares the nibble-serial memory port between the
// instruction fetcher and the load/store path.
// Arbitration happens only in IDLE. Data normally wins, but fetch wins
// right after a data transaction. A 4-bit counter tracks the nibbles of
// the current transaction. A fetch can be aborted with instr_cancel, which
// drives mem_stop.
module tiny45_mem_arbiter #(
  parameter int unsigned FETCH_NIBBLES = 8  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rstn,
  // instruction fetcher
  input  logic        instr_req,
  input  logic [27:0] instr_addr,
  input  logic        instr_cancel,
  output logic [3:0]  instr_rdata,
  output logic        instr_rvalid,
  output logic        instr_done,
  // load/store path
  input  logic        data_req,
  input  logic [27:0] data_addr,
  input  logic        data_write,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wdata,
  output logic        data_wnext,
  output logic [3:0]  data_rdata,
  output logic        data_rvalid,
  output logic        data_done,
  // memory controller
  output logic        mem_start,
  output logic [27:0] mem_addr,
  output logic        mem_write,
  output logic [3:0]  mem_nibbles,
  output logic [3:0]  mem_wdata,
  input  logic        mem_wready,
  input  logic [3:0]  mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_stop
);

  typedef enum logic [1:0] {IDLE, FETCH, DREAD, DWRITE} state_e;

  localparam logic [3:0] FETCH_LEN = 4'(FETCH_NIBBLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_was_data_q, last_was_data_d;
  logic        mem_start_q, mem_start_d;
  logic [27:0] mem_addr_q, mem_addr_d;
  logic        mem_write_q, mem_write_d;
  logic [3:0]  mem_nibbles_q, mem_nibbles_d;

  logic        st_idle, st_fetch, st_dread, st_dwrite;
  logic        fetch_ok, data_wins, grant_data, grant_fetch;
  logic [3:0]  data_len;
  logic        cnt_last;

  assign st_idle   = (state_q == IDLE);
  assign st_fetch  = (state_q == FETCH);
  assign st_dread  = (state_q == DREAD);
  assign st_dwrite = (state_q == DWRITE);
  assign cnt_last  = (cnt_q == 4'd1);

  // A cancel seen in IDLE suppresses the fetch request for that cycle only.
  assign fetch_ok    = instr_req & ~instr_cancel;
  // Data has priority unless the previous transaction was also data.
  assign data_wins   = data_req & ~(last_was_data_q & fetch_ok);
  assign grant_data  = st_idle & data_wins;
  assign grant_fetch = st_idle & fetch_ok & ~data_wins;

  // Map the transfer size to a nibble count. Word is 8 nibbles; 11 aliases word.
  always_comb begin
    data_len = 4'd8;
    case (data_size)
      2'b00:   data_len = 4'd2;
      2'b01:   data_len = 4'd4;
      default: data_len = 4'd8;
    endcase
  end

  // Next-state logic: grant in IDLE, then count handshakes down to 1.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    last_was_data_d = last_was_data_q;
    mem_start_d     = 1'b0;
    mem_addr_d      = mem_addr_q;
    mem_write_d     = mem_write_q;
    mem_nibbles_d   = mem_nibbles_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d         = data_write ? DWRITE : DREAD;
          cnt_d           = data_len;
          last_was_data_d = 1'b1;
          mem_start_d     = 1'b1;
          mem_addr_d      = data_addr;
          mem_write_d     = data_write;
          mem_nibbles_d   = data_len;
        end else if (grant_fetch) begin
          state_d         = FETCH;
          cnt_d           = FETCH_LEN;
          last_was_data_d = 1'b0;
          mem_start_d     = 1'b1;
          mem_addr_d      = instr_addr;
          mem_write_d     = 1'b0;
          mem_nibbles_d   = FETCH_LEN;
        end
      end
      FETCH: begin
        // Cancel takes precedence over a nibble arriving in the same cycle.
        if (instr_cancel) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (mem_rvalid) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_last) state_d = IDLE;
        end
      end
      DREAD: begin
        if (mem_rvalid) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_last) state_d = IDLE;
        end
      end
      DWRITE: begin
        if (mem_wready) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered memory-side outputs; reset drops any transaction.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q         <= IDLE;
      cnt_q           <= 4'd0;
      last_was_data_q <= 1'b0;
      mem_start_q     <= 1'b0;
      mem_addr_q      <= 28'd0;
      mem_write_q     <= 1'b0;
      mem_nibbles_q   <= 4'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_was_data_q <= last_was_data_d;
      mem_start_q     <= mem_start_d;
      mem_addr_q      <= mem_addr_d;
      mem_write_q     <= mem_write_d;
      mem_nibbles_q   <= mem_nibbles_d;
    end
  end

  // Handshake routing. Data paths are gated by state so IDLE outputs stay 0.
  assign mem_start    = mem_start_q;
  assign mem_addr     = mem_addr_q;
  assign mem_write    = mem_write_q;
  assign mem_nibbles  = mem_nibbles_q;
  assign mem_stop     = st_fetch & instr_cancel;
  assign mem_wdata    = st_dwrite ? data_wdata : 4'd0;

  assign instr_rdata  = st_fetch ? mem_rdata : 4'd0;
  assign instr_rvalid = st_fetch & mem_rvalid & ~instr_cancel;
  assign instr_done   = instr_rvalid & cnt_last;

  assign data_rdata   = st_dread ? mem_rdata : 4'd0;
  assign data_rvalid  = st_dread & mem_rvalid;
  assign data_wnext   = st_dwrite & mem_wready;
  assign data_done    = (data_rvalid | data_wnext) & cnt_last;

endmodule

// File: tb/tb_tiny45_mem_arbiter.sv
// Directed bench for tiny45_mem_arbiter: per-cycle vector table plus a
// hand-written reset-mid-store sequence.
module tb_tiny45_mem_arbiter;

  localparam logic [27:0] IA = 28'h0000100;
  localparam logic [27:0] DA = 28'h1000004;

  // flag bits {start, stop, irv, idone, drv, ddone, wnext}
  localparam logic [6:0] S  = 7'b1000000;
  localparam logic [6:0] ST = 7'b0100000;
  localparam logic [6:0] IV = 7'b0010000;
  localparam logic [6:0] ID = 7'b0001000;
  localparam logic [6:0] DV = 7'b0000100;
  localparam logic [6:0] DD = 7'b0000010;
  localparam logic [6:0] WN = 7'b0000001;

  logic        clk = 1'b0;
  logic        rstn;
  logic        instr_req, instr_cancel, instr_rvalid, instr_done;
  logic [27:0] instr_addr, data_addr, mem_addr;
  logic [3:0]  instr_rdata, data_wdata, data_rdata, mem_nibbles, mem_wdata, mem_rdata;
  logic        data_req, data_write, data_wnext, data_rvalid, data_done;
  logic [1:0]  data_size;
  logic        mem_start, mem_write, mem_wready, mem_rvalid, mem_stop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tiny45_mem_arbiter #(.FETCH_NIBBLES(8)) dut (
    .clk(clk), .rstn(rstn),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_cancel(instr_cancel),
    .instr_rdata(instr_rdata), .instr_rvalid(instr_rvalid), .instr_done(instr_done),
    .data_req(data_req), .data_addr(data_addr), .data_write(data_write),
    .data_size(data_size), .data_wdata(data_wdata), .data_wnext(data_wnext),
    .data_rdata(data_rdata), .data_rvalid(data_rvalid), .data_done(data_done),
    .mem_start(mem_start), .mem_addr(mem_addr), .mem_write(mem_write),
    .mem_nibbles(mem_nibbles), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .mem_stop(mem_stop)
  );

  typedef struct packed {
    logic       rstn;
    logic       ireq;
    logic       icn;
    logic       dreq;
    logic       dwr;
    logic [1:0] dsz;
    logic [3:0] wd;
    logic       wrdy;
    logic       rv;
    logic [3:0] rd;
    logic [6:0] e_flags;
    logic       e_wr;
    logic [3:0] e_nib;
    logic [1:0] e_a;    // 0: zero, 1: IA, 2: DA
    logic [3:0] e_wd;
    logic [3:0] e_ird;
    logic [3:0] e_drd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic ireq, logic icn, logic dreq, logic dwr, logic [1:0] dsz,
                              logic [3:0] wd, logic wrdy, logic rv, logic [3:0] rd,
                              logic [6:0] fl, logic wr, logic [3:0] nib, logic [1:0] a,
                              logic [3:0] ewd, logic [3:0] eird, logic [3:0] edrd);
    vec_t v;
    v = '{rstn: 1'b1, ireq: ireq, icn: icn, dreq: dreq, dwr: dwr, dsz: dsz, wd: wd,
          wrdy: wrdy, rv: rv, rd: rd, e_flags: fl, e_wr: wr, e_nib: nib, e_a: a,
          e_wd: ewd, e_ird: eird, e_drd: edrd};
    return v;
  endfunction

  task automatic check(input string tag, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then check outputs 1ns later.
  task automatic apply(input vec_t v, input string tag);
    logic [27:0] ea;
    @(negedge clk);
    rstn = v.rstn; instr_req = v.ireq; instr_cancel = v.icn;
    data_req = v.dreq; data_write = v.dwr; data_size = v.dsz; data_wdata = v.wd;
    mem_wready = v.wrdy; mem_rvalid = v.rv; mem_rdata = v.rd;
    #1;
    ea = (v.e_a == 2'd1) ? IA : (v.e_a == 2'd2) ? DA : 28'd0;
    check(tag, "flags", 32'({mem_start, mem_stop, instr_rvalid, instr_done,
                             data_rvalid, data_done, data_wnext}), 32'(v.e_flags));
    check(tag, "mem_write",   32'(mem_write),   32'(v.e_wr));
    check(tag, "mem_nibbles", 32'(mem_nibbles), 32'(v.e_nib));
    check(tag, "mem_addr",    32'(mem_addr),    32'(ea));
    check(tag, "mem_wdata",   32'(mem_wdata),   32'(v.e_wd));
    check(tag, "instr_rdata", 32'(instr_rdata), 32'(v.e_ird));
    check(tag, "data_rdata",  32'(data_rdata),  32'(v.e_drd));
  endtask

  initial begin
    vec_t v;
    logic [3:0] wd;
    rstn = 1'b0; instr_req = 1'b0; instr_cancel = 1'b0; instr_addr = IA;
    data_req = 1'b0; data_addr = DA; data_write = 1'b0; data_size = 2'b00;
    data_wdata = 4'd0; mem_wready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 4'd0;
    repeat (3) @(posedge clk);

    // fetch 8 nibbles, rvalid every cycle
    vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,     0,0,0, 0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0, 0,     0,0,0, 0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,1,3, S|IV,  0,8,1, 0,3,0));
    for (int k = 0; k < 6; k++)
      vq.push_back(mk(1,0,0,0,0,0,0,1,0, IV,  0,8,1, 0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,1,0, IV|ID, 0,8,1, 0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,     0,8,1, 0,0,0));
    // simultaneous requests: data first, then fetch beats re-raised data
    vq.push_back(mk(1,0,1,0,0,0,0,0,0, 0,     0,8,1, 0,0,0));
    vq.push_back(mk(1,0,1,0,0,0,0,1,5, S|DV,  0,2,2, 0,0,5));
    vq.push_back(mk(1,0,1,0,0,0,0,1,6, DV|DD, 0,2,2, 0,0,6));
    vq.push_back(mk(1,0,1,0,0,0,0,0,0, 0,     0,2,2, 0,0,0));
    vq.push_back(mk(1,0,1,0,0,0,0,1,1, S|IV,  0,8,1, 0,1,0));
    vq.push_back(mk(1,0,1,0,0,0,0,1,2, IV,    0,8,1, 0,2,0));
    vq.push_back(mk(1,0,1,0,0,0,0,1,4, IV,    0,8,1, 0,4,0));
    // cancel after 3 nibbles; pending data granted next
    vq.push_back(mk(1,1,1,0,0,0,0,1,7, ST,    0,8,1, 0,7,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,0, 0,     0,8,1, 0,0,0));
    vq.push_back(mk(0,0,1,0,0,0,1,1,9, S|DV,  0,2,2, 0,0,9));   // wready ignored in DREAD
    vq.push_back(mk(0,1,1,0,0,0,1,0,0, 0,     0,2,2, 0,0,0));   // cancel ignored in DREAD
    vq.push_back(mk(0,0,1,0,0,0,0,1,10, DV|DD, 0,2,2, 0,0,10));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,     0,2,2, 0,0,0));
    // store word 0x12345678, wready every other cycle
    vq.push_back(mk(0,0,1,1,2,8,0,0,0, 0,     0,2,2, 0,0,0));
    vq.push_back(mk(0,0,1,1,2,8,0,1,5, S,     1,8,2, 8,0,0));   // rvalid ignored in DWRITE
    for (int k = 0; k < 8; k++) begin
      wd = 4'(8 - k);
      vq.push_back(mk(0,0,1,1,2,wd,1,0,0, (k == 7) ? (WN|DD) : WN, 1,8,2, wd,0,0));
      if (k < 7) begin
        wd = 4'(7 - k);
        vq.push_back(mk(0,0,1,1,2,wd,0,0,0, 0, 1,8,2, wd,0,0));
      end
    end
    vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,     1,8,2, 0,0,0));
    // cancel in IDLE blocks grant; then cancel coincident with 8th nibble
    vq.push_back(mk(1,1,0,0,0,0,0,0,0, 0,     1,8,2, 0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,0,0, 0,     1,8,2, 0,0,0));
    vq.push_back(mk(1,0,0,0,0,0,0,1,1, S|IV,  0,8,1, 0,1,0));
    for (int k = 2; k < 8; k++)
      vq.push_back(mk(1,0,0,0,0,0,0,1,4'(k), IV, 0,8,1, 0,4'(k),0));
    vq.push_back(mk(1,1,0,0,0,0,0,1,15, ST,   0,8,1, 0,15,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,0, 0,     0,8,1, 0,0,0));

    foreach (vq[i]) apply(vq[i], $sformatf("row%0d", i));

    // reset in the middle of a half-word store, then a fresh fetch
    apply(mk(0,0,1,1,1,5,0,0,0, 0,     0,8,1, 0,0,0), "rst_grant");
    apply(mk(0,0,1,1,1,5,1,0,0, S|WN,  1,4,2, 5,0,0), "rst_w1");
    apply(mk(0,0,1,1,1,6,1,0,0, WN,    1,4,2, 6,0,0), "rst_w2");
    v = mk(0,0,1,1,1,7,0,0,0, 0, 1,4,2, 7,0,0);
    v.rstn = 1'b0;
    apply(v, "rst_low");
    apply(mk(1,0,0,0,0,0,0,0,0, 0,     0,0,0, 0,0,0), "rst_idle");
    apply(mk(1,0,0,0,0,0,0,1,2, S|IV,  0,8,1, 0,2,0), "rst_f1");
    for (int k = 0; k < 6; k++)
      apply(mk(1,0,0,0,0,0,0,1,0, IV,  0,8,1, 0,0,0), $sformatf("rst_f%0d", k + 2));
    apply(mk(1,0,0,0,0,0,0,1,0, IV|ID, 0,8,1, 0,0,0), "rst_f8");
    apply(mk(0,0,0,0,0,0,0,0,0, 0,     0,8,1, 0,0,0), "rst_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
